// File: rtl/disp_src_scan.sv
`default_nettype none
// ============================================================================
//  Module   : disp_src_scan
//  Purpose  : Display-source stage for the 8-digit seven-segment driver.
//             Selects a CPU debug source (reg file, data mem, PC, instr),
//             steps a read index from a debounced button or an auto-scan
//             timer, and registers the 32-bit display word with a hold.
//  Revision : 1.0  initial release
// ============================================================================
module disp_src_scan #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int SCAN_PERIOD = 25000000,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_mode,
    input  logic             i_auto,
    input  logic             i_hold,
    input  logic             i_btn_step,
    input  logic [31:0]      i_rf_data,
    input  logic [31:0]      i_dm_data,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_instr,
    output logic [IDX_W-1:0] o_rd_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_step,
    output logic [31:0]      o_disp_data
);

    localparam int DEB_W  = (DEB_CYCLES  > 2) ? $clog2(DEB_CYCLES)  : 1;
    localparam int SCAN_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    localparam logic [1:0] MODE_RF    = 2'b00;
    localparam logic [1:0] MODE_DM    = 2'b01;
    localparam logic [1:0] MODE_PC    = 2'b10;
    localparam logic [1:0] MODE_INSTR = 2'b11;

    logic              sync1;
    logic              sync2;
    logic              deb_level;
    logic [DEB_W-1:0]  deb_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        mode_q;
    logic [IDX_W-1:0]  idx;
    logic              step_q;
    logic [31:0]       disp_q;
    logic [31:0]       src_word;

    // A new debounced level is accepted only after the synchronised input
    // has disagreed with it for DEB_CYCLES consecutive cycles.
    logic deb_accept;
    assign deb_accept = (sync2 != deb_level) && (deb_cnt == DEB_LAST);

    // Only the press (0->1 acceptance) steps the index; release is silent.
    logic btn_pulse;
    assign btn_pulse = deb_accept && sync2;

    logic scan_pulse;
    assign scan_pulse = i_auto && (scan_cnt == SCAN_LAST);

    logic mode_chg;
    assign mode_chg = (i_mode != mode_q);

    // Coincident button and scan pulses merge into a single advance.
    logic step;
    assign step = btn_pulse || scan_pulse;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn_step;
            sync2 <= sync1;
        end
    end

    // Debounce: count disagreement cycles, clear on agreement or acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync2 == deb_level) begin
            deb_cnt   <= '0;
        end else if (deb_accept) begin
            deb_cnt   <= '0;
            deb_level <= sync2;
        end else begin
            deb_cnt   <= deb_cnt + DEB_W'(1);
        end
    end

    // Auto-scan timer: idle at zero when disabled, restarts on a mode change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (!i_auto || mode_chg || scan_pulse) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Index and step flag; a mode change zeroes the index and swallows a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_RF;
            idx    <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= i_mode;
            if (mode_chg) begin
                idx    <= '0;
                step_q <= 1'b0;
            end else begin
                step_q <= step;
                if (step) begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Source selection follows the stored mode so the data lags it by one edge.
    always_comb begin
        src_word = i_rf_data;
        case (mode_q)
            MODE_RF:    src_word = i_rf_data;
            MODE_DM:    src_word = i_dm_data;
            MODE_PC:    src_word = i_pc;
            MODE_INSTR: src_word = i_instr;
            default:    src_word = i_rf_data;
        endcase
    end

    // Display register; hold freezes the word while index/mode keep moving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
        end else if (!i_hold) begin
            disp_q <= src_word;
        end
    end

    assign o_rd_addr   = idx;
    assign o_idx       = idx;
    assign o_step      = step_q;
    assign o_disp_data = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_src_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_src_scan
//  Purpose  : Self-checking bench for disp_src_scan (debounce, auto-scan
//             wrap, coincident events, source select, hold, async reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_disp_src_scan;

    localparam int DEB  = 4;
    localparam int SCAN = 8;
    localparam int IW   = 5;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          auto_en;
    logic          hold;
    logic          btn;
    logic [31:0]   rf_data;
    logic [31:0]   dm_data;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [IW-1:0] rd_addr;
    logic [IW-1:0] idx;
    logic          step;
    logic [31:0]   disp;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] e;

    disp_src_scan #(.DEB_CYCLES(DEB), .SCAN_PERIOD(SCAN), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .i_mode(mode), .i_auto(auto_en), .i_hold(hold),
        .i_btn_step(btn), .i_rf_data(rf_data), .i_dm_data(dm_data),
        .i_pc(pc), .i_instr(instr), .o_rd_addr(rd_addr), .o_idx(idx),
        .o_step(step), .o_disp_data(disp)
    );

    // Memory models respond combinationally to the read address.
    assign rf_data = 32'h1000_0000 + 32'(rd_addr);
    assign dm_data = (rd_addr == 5'd3) ? 32'hDEAD_BEEF : 32'h2000_0000 + 32'(rd_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = 1'b0; auto_en = 1'b0; hold = 1'b0; mode = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // One full press/release; reports steps seen and the index at the step.
    task automatic press(output int steps, output logic [IW-1:0] sidx);
        steps = 0; sidx = '0;
        btn = 1'b1;
        repeat (DEB + 5) begin
            @(negedge clk);
            if (step) begin steps++; sidx = idx; end
        end
        btn = 1'b0;
        repeat (DEB + 5) begin
            @(negedge clk);
            if (step) begin steps++; sidx = idx; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; auto_en = 1'b0; hold = 1'b0; mode = 2'b00;
        pc = 32'h0000_0040; instr = 32'h0051_0113;
        @(negedge clk);
        total_cnt++;
        if ({idx, rd_addr, step, disp} !== '0) $display("FAIL reset_state: idx=%0d addr=%0d step=%b disp=%h required all 0", idx, rd_addr, step, disp);
        else pass_cnt++;
    endtask

    task automatic test_debounce();
        int bounce_steps = 0;
        int steps = 0;
        int lat = -1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step) bounce_steps++;
            btn = (i % 2 == 1);
        end
        exp_q.push_back(5'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (step) begin
                steps++;
                if (lat < 0) lat = c;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL deb_step: unexpected step idx=%0d", idx);
                else begin
                    e = exp_q.pop_front();
                    if (idx !== e) $display("FAIL deb_step_idx: got %0d required %0d", idx, e);
                    else pass_cnt++;
                end
            end
            if (lat > 0 && c == lat + 1) begin
                total_cnt++;
                if (disp !== 32'h1000_0001 || idx !== 5'd1) $display("FAIL deb_disp: got disp=%h idx=%0d required 10000001/1", disp, idx);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bounce_steps != 0) $display("FAIL deb_bounce: got %0d steps while bouncing required 0", bounce_steps);
        else pass_cnt++;
        total_cnt++;
        if (steps != 1) $display("FAIL deb_count: got %0d steps required 1", steps);
        else pass_cnt++;
        total_cnt++;
        if (lat < 5 || lat > 7) $display("FAIL deb_latency: got %0d cycles required about 6", lat);
        else pass_cnt++;
        btn = 1'b0;
        steps = 0;
        repeat (DEB + 6) begin @(negedge clk); if (step) steps++; end
        total_cnt++;
        if (steps != 0) $display("FAIL deb_release: got %0d steps on release required 0", steps);
        else pass_cnt++;
    endtask

    task automatic test_scan_wrap();
        int steps = 0;
        int last = 0;
        int addr_err = 0;
        int gap_err = 0;
        do_reset();
        auto_en = 1'b1;
        for (int k = 1; k <= 33; k++) exp_q.push_back(IW'(k % 32));
        for (int c = 1; c <= 33 * SCAN + 4; c++) begin
            @(negedge clk);
            if (rd_addr !== idx) addr_err++;
            if (step) begin
                steps++;
                if (c - last != SCAN) gap_err++;
                last = c;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL scan_step: unexpected step idx=%0d", idx);
                else begin
                    e = exp_q.pop_front();
                    if (idx !== e) $display("FAIL scan_idx: got %0d required %0d", idx, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (addr_err != 0) $display("FAIL scan_rd_addr: got %0d cycles with rd_addr!=idx required 0", addr_err);
        else pass_cnt++;
        total_cnt++;
        if (gap_err != 0) $display("FAIL scan_period: got %0d bad step gaps required 0", gap_err);
        else pass_cnt++;
        total_cnt++;
        if (steps != 33 || exp_q.size() != 0) $display("FAIL scan_count: got %0d steps required 33", steps);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int steps = 0;
        do_reset();
        auto_en = 1'b1;
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd1);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (step) begin
                steps++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL sim_step: unexpected step at cycle %0d idx=%0d", c, idx);
                else begin
                    e = exp_q.pop_front();
                    if (idx !== e) $display("FAIL sim_idx: got %0d required %0d", idx, e);
                    else pass_cnt++;
                end
            end
            if (c == 2) btn = 1'b1;
            if (c == 8) begin
                total_cnt++;
                if (step !== 1'b1 || idx !== 5'd1) $display("FAIL sim_coincident: got step=%b idx=%0d required 1/1", step, idx);
                else pass_cnt++;
            end
            if (c == 15) mode = 2'b01;
            if (c == 16) begin
                total_cnt++;
                if (step !== 1'b0 || idx !== 5'd0) $display("FAIL sim_mode_wins: got step=%b idx=%0d required 0/0", step, idx);
                else pass_cnt++;
            end
            if (c == 24) begin
                total_cnt++;
                if (step !== 1'b1) $display("FAIL sim_scan_restart: got step=%b at cycle 24 required 1", step);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (steps != 2) $display("FAIL sim_count: got %0d steps required 2", steps);
        else pass_cnt++;
        btn = 1'b0;
    endtask

    task automatic test_source_select();
        int steps;
        logic [IW-1:0] sidx;
        do_reset();
        repeat (2) @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        total_cnt++;
        if (disp !== 32'h1000_0000) $display("FAIL sel_pc_latency: got %h required 10000000", disp);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (disp !== 32'h0000_0040) $display("FAIL sel_pc: got %h required 00000040", disp);
        else pass_cnt++;
        mode = 2'b11;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (disp !== 32'h0051_0113) $display("FAIL sel_instr: got %h required 00510113", disp);
        else pass_cnt++;
        exp_q.push_back(5'd1);
        press(steps, sidx);
        e = exp_q.pop_front();
        total_cnt++;
        if (steps != 1 || sidx !== e) $display("FAIL sel_instr_step: got %0d steps idx=%0d required 1/%0d", steps, sidx, e);
        else pass_cnt++;
        mode = 2'b01;
        @(negedge clk);
        total_cnt++;
        if (idx !== 5'd0) $display("FAIL sel_mode_clear: got idx=%0d required 0", idx);
        else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(IW'(k));
            press(steps, sidx);
            e = exp_q.pop_front();
            total_cnt++;
            if (steps != 1 || sidx !== e) $display("FAIL sel_dm_step: got %0d steps idx=%0d required 1/%0d", steps, sidx, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (disp !== 32'hDEAD_BEEF) $display("FAIL sel_dm: got %h required deadbeef", disp);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int steps;
        logic [IW-1:0] sidx;
        do_reset();
        repeat (3) @(negedge clk);
        hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(IW'(k));
            press(steps, sidx);
            e = exp_q.pop_front();
            total_cnt++;
            if (steps != 1 || sidx !== e) $display("FAIL hold_step: got %0d steps idx=%0d required 1/%0d", steps, sidx, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (disp !== 32'h1000_0000 || idx !== 5'd3) $display("FAIL hold_frozen: got disp=%h idx=%0d required 10000000/3", disp, idx);
        else pass_cnt++;
        hold = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (disp !== 32'h1000_0003) $display("FAIL hold_release: got %h required 10000003", disp);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int first = -1;
        int steps = 0;
        do_reset();
        auto_en = 1'b1;
        for (int k = 1; k <= 7; k++) exp_q.push_back(IW'(k));
        for (int c = 1; c <= 7 * SCAN; c++) begin
            @(negedge clk);
            if (step) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL ar_step: unexpected step idx=%0d", idx);
                else begin
                    e = exp_q.pop_front();
                    if (idx !== e) $display("FAIL ar_idx: got %0d required %0d", idx, e);
                    else pass_cnt++;
                end
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({idx, rd_addr, step, disp} !== '0) $display("FAIL ar_immediate: idx=%0d addr=%0d step=%b disp=%h required all 0", idx, rd_addr, step, disp);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(5'd1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (step) begin
                steps++;
                if (first < 0) first = c;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL ar_post_step: unexpected step idx=%0d", idx);
                else begin
                    e = exp_q.pop_front();
                    if (idx !== e) $display("FAIL ar_post_idx: got %0d required %0d", idx, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (first != SCAN || steps != 1) $display("FAIL ar_first_step: got cycle %0d (%0d steps) required %0d (1 step)", first, steps, SCAN);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_scan_wrap();
        test_simultaneous();
        test_source_select();
        test_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
